cfg_row_loader: RTL
===================

# cfg_row_loader

Parametrised configuration loader for one row of connection-block cells. It generalises the fixed 8-cell daisy-chain row in three ways: cell count and bits per cell are parameters, configuration is double-buffered, and the block adds frame-length and parity checking, explicit commit and active-configuration readback. It sits between the serial programming chain and the cell configuration inputs of a row. `prog_out` daisy-chains to the next row.

## Interface
Parameters:
- `NUM_CELLS`, 8, number of cells in the row.
- `CELL_BITS`, 16, configuration bits per cell; must be a multiple of 4.
- `REVERSE`, 0, odd-row mode.
  - 1: every 4-bit group of `cfg_active` is bit-reversed at the output.
  - 0: straight through.
- Derived: `TOTAL` = `NUM_CELLS*CELL_BITS`. `CW` = `$clog2(TOTAL+3)`.

Ports:
- `prog_clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `prog_in` in 1: serial configuration data, qualified by `prog_en`.
- `prog_en` in 1: shift enable. One bit moves per cycle while high.
- `commit` in 1: single-cycle request to apply the shadow frame.
- `readback` in 1: single-cycle request to shift the active configuration out.
- `prog_out` out 1: serial output (chain pass-through or readback data).
- `cfg_active` out `TOTAL`: active configuration to the cells. Cell k owns bits [k*CELL_BITS +: CELL_BITS].
- `cfg_valid` out 1: at least one successful commit since reset.
- `commit_done` out 1: one-cycle pulse on a successful commit.
- `err` out 1: sticky error flag.
- `busy` out 1: high in LOAD or READBACK.
- `bit_cnt` out `CW`: bits shifted in since the last commit; saturates at 2^CW-1.

## Operation
- Shift register `sr` is `TOTAL+1` bits wide.
  - On each `prog_en` cycle: `sr <= {sr[TOTAL-1:0], prog_in}`.
  - In IDLE/LOAD, `prog_out` = `sr[TOTAL]`, so excess bits pass through to the next row.
- Frame format: `TOTAL` data bits, MSB of the highest cell first, then 1 even-parity bit.
  - A frame is good when `bit_cnt == TOTAL+1` and the XOR of all `sr` bits is 0.
  - On a good commit, `cfg_active` (before the `REVERSE` mapping) <= `sr[TOTAL:1]`.
- States: IDLE, LOAD, READBACK.
  - IDLE, `prog_en` = 1 -> LOAD. That bit is shifted and `bit_cnt` becomes 1.
  - IDLE, `readback` = 1 (with `prog_en` = 0) -> READBACK.
  - IDLE, `commit` = 1 -> `err` set, nothing else changes.
  - LOAD, `prog_en` = 1 -> shift and increment `bit_cnt`.
  - LOAD, `commit` = 1, good frame -> update `cfg_active`, `cfg_valid` <= 1, `commit_done` pulse, `bit_cnt` <= 0, go to IDLE.
  - LOAD, `commit` = 1, bad length or parity -> `err` <= 1, `cfg_active` unchanged, `bit_cnt` <= 0, go to IDLE.
  - LOAD, `readback` is ignored.
  - READBACK, on entry: `rb` <= {`cfg_active` raw, XOR of `cfg_active`}. `prog_out` = `rb[TOTAL]`.
  - READBACK, each `prog_en` cycle: shift `rb` left, decrement the remaining count. After `TOTAL+1` shifts -> IDLE.
  - READBACK, `commit` and `readback` are ignored. `sr` is frozen.
- Simultaneous events:
  - `commit` with `prog_en` in LOAD: `commit` is evaluated on `sr`/`bit_cnt` before this cycle; the concurrent bit is discarded and no error is raised.
  - `prog_en` with `readback` in IDLE: `prog_en` wins (go to LOAD).
- `REVERSE` = 1 mapping: output bits [4g+3:4g] = raw {b0,b1,b2,b3} of group g. Readback always uses the raw order.
- `err` is cleared only by `rst`.

## Timing
- All state is registered on the rising edge of `prog_clk`. `rst` clears everything immediately and asynchronously.
- Reset values: `cfg_active` = 0, `cfg_valid` = 0, `commit_done` = 0, `err` = 0, `busy` = 0, `bit_cnt` = 0, `prog_out` = 0. State = IDLE; `sr` and `rb` = 0.
- Reset mid-LOAD or mid-READBACK aborts the operation. `cfg_active` returns to 0, not the last committed value.
- Commit latency: with `commit` sampled at edge N, `cfg_active`, `cfg_valid` and `commit_done` change after edge N. `commit_done` is high for exactly the cycle after N.
- Pass-through latency: a bit presented at `prog_in` appears on `prog_out` after `TOTAL+1` enabled shifts.
- Readback: the first bit (`cfg_active[TOTAL-1]`) is valid the cycle after entry. The parity bit is valid after `TOTAL` shifts. `busy` drops the cycle after the final shift.

## Test plan
Configuration: `NUM_CELLS` = 2, `CELL_BITS` = 4, `TOTAL` = 8.
- Shift 8'hA5 MSB first, then parity 0, then `commit` -> `cfg_active` = 8'hA5, `cfg_valid` = 1, one `commit_done` pulse, `err` = 0, `bit_cnt` = 0.
- Shift 8'hA5 with parity 1, then `commit` -> `err` = 1, `cfg_active` keeps its prior value. Repeat with only 8 bits, and with 10 bits -> `err` = 1.
- After a good 8'h3C commit, `readback` with `prog_en` held -> `prog_out` gives 0,0,1,1,1,1,0,0 then parity 0; `busy` falls after shift 9.
- `REVERSE` = 1, commit 8'h12 -> `cfg_active` = 8'h84.
- Assert `rst` after 5 bits of a frame -> all outputs 0 and state IDLE. A following clean 9-bit frame commits correctly.
- Assert `commit` and `prog_en` together on bit 10 of a good 9-bit frame -> commit succeeds and the 10th bit is discarded.

Source files
------------

// File: rtl/cfg_row_loader.sv
// Configuration loader for one row of connection-block cells: serial shift-in,
// length/parity-checked commit into a double-buffered active register, and readback.
module cfg_row_loader #(
  parameter int NUM_CELLS = 8,
  parameter int CELL_BITS = 16,
  parameter bit REVERSE   = 1'b0
) (
  input  logic                                         prog_clk,
  input  logic                                         rst,
  input  logic                                         prog_in,
  input  logic                                         prog_en,
  input  logic                                         commit,
  input  logic                                         readback,
  output logic                                         prog_out,
  output logic [NUM_CELLS*CELL_BITS-1:0]               cfg_active,
  output logic                                         cfg_valid,
  output logic                                         commit_done,
  output logic                                         err,
  output logic                                         busy,
  output logic [$clog2(NUM_CELLS*CELL_BITS+3)-1:0]     bit_cnt,
  output logic [1:0]                                   dbg_state_o
);

  localparam int TOTAL = NUM_CELLS * CELL_BITS;
  localparam int CW    = $clog2(TOTAL + 3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_READBACK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TOTAL:0]   sr_q, sr_d;
  logic [TOTAL:0]   rb_q, rb_d;
  logic [CW-1:0]    rb_cnt_q, rb_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TOTAL-1:0] cfg_q, cfg_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             frame_good;

  // A frame is accepted only if exactly TOTAL data bits plus parity arrived and
  // the whole shift register has even parity.
  assign frame_good = (bit_cnt_q == CW'(TOTAL + 1)) && !(^sr_q);

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      rb_q      <= '0;
      rb_cnt_q  <= '0;
      bit_cnt_q <= '0;
      cfg_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      rb_q      <= rb_d;
      rb_cnt_q  <= rb_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_q     <= cfg_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    rb_d      = rb_q;
    rb_cnt_d  = rb_cnt_q;
    bit_cnt_d = bit_cnt_q;
    cfg_d     = cfg_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) err_d = 1'b1;
        if (prog_en) begin
          sr_d      = {sr_q[TOTAL-1:0], prog_in};
          bit_cnt_d = CW'(1);
          state_d   = ST_LOAD;
        end else if (readback) begin
          rb_d     = {cfg_q, ^cfg_q};
          rb_cnt_d = CW'(TOTAL + 1);
          state_d  = ST_READBACK;
        end
      end
      ST_LOAD: begin
        // Commit takes priority; a bit shifted in the same cycle is dropped.
        if (commit) begin
          if (frame_good) begin
            cfg_d   = sr_q[TOTAL:1];
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (prog_en) begin
          sr_d = {sr_q[TOTAL-1:0], prog_in};
          if (bit_cnt_q != {CW{1'b1}}) bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_READBACK: begin
        if (prog_en) begin
          rb_d     = {rb_q[TOTAL-1:0], 1'b0};
          rb_cnt_d = rb_cnt_q - CW'(1);
          if (rb_cnt_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prog_out    = (state_q == ST_READBACK) ? rb_q[TOTAL] : sr_q[TOTAL];
  assign cfg_valid   = valid_q;
  assign commit_done = done_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign bit_cnt     = bit_cnt_q;
  assign dbg_state_o = state_q;

  // Odd rows see each nibble bit-reversed; readback always uses raw order.
  generate
    if (REVERSE) begin : g_rev
      for (genvar g = 0; g < TOTAL / 4; g++) begin : g_grp
        for (genvar j = 0; j < 4; j++) begin : g_bit
          assign cfg_active[4*g+j] = cfg_q[4*g+3-j];
        end
      end
    end else begin : g_straight
      assign cfg_active = cfg_q;
    end
  endgenerate

endmodule
